// File: rtl/serial_rx_control.sv
// serial_rx_control
//   Receive-side controller for a one-bit-per-clock serial link. Waits for a
//   start bit (Din low) while idle, shifts WIDTH data bits in LSB first,
//   optionally checks an even-parity bit, checks the stop bit and hands the
//   assembled word to the consumer through a level Valid/Ack handshake.
//
//   Optional feature macro: SERIAL_RX_PARITY_EN
//     defined   -> a PARITY state follows the data bits; Parity_Err is live
//                  and a word with bad parity is never delivered.
//     undefined -> DATA goes straight to STOP; Parity_Err is constant 0.
//
// Ports
//   Clk        in   system clock, rising edge
//   Reset_n    in   asynchronous active-low reset
//   Din        in   serial line, idle high
//   Ack        in   consumer acknowledge; clears Valid and Overrun
//   Data_Out   out  [WIDTH-1:0] last good received word
//   Valid      out  Data_Out holds an unacknowledged word
//   Busy       out  frame in progress (state != IDLE)
//   Frame_Err  out  one-cycle pulse, stop bit sampled low
//   Parity_Err out  one-cycle pulse, parity mismatch
//   Overrun    out  sticky, a good word overwrote an unacknowledged one
module serial_rx_control #(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Din,
  input  logic             Ack,
  output logic [WIDTH-1:0] Data_Out,
  output logic             Valid,
  output logic             Busy,
  output logic             Frame_Err,
  output logic             Parity_Err,
  output logic             Overrun
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DATA   = 2'd1;
`ifdef SERIAL_RX_PARITY_EN
  localparam logic [1:0] S_PARITY = 2'd2;
`endif
  localparam logic [1:0] S_STOP   = 2'd3;

  localparam int               CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] shift;

`ifdef SERIAL_RX_PARITY_EN
  logic par_bad;

  // Even parity: data bits plus parity bit must contain an even number of ones.
  function automatic logic parity_mismatch(input logic [WIDTH-1:0] d, input logic p);
    return (^d) ^ p;
  endfunction
`endif

  assign Busy = (state != S_IDLE);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      shift     <= '0;
      Data_Out  <= '0;
      Valid     <= 1'b0;
      Frame_Err <= 1'b0;
      Overrun   <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
      par_bad    <= 1'b0;
      Parity_Err <= 1'b0;
`endif
    end else begin
      Frame_Err <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
      Parity_Err <= 1'b0;
`endif
      // Ack clears the handshake unless a good word loads below, which overrides it.
      if (Ack) begin
        Valid   <= 1'b0;
        Overrun <= 1'b0;
      end

      case (state)
        S_IDLE: begin
          if (!Din) begin
            state <= S_DATA;
            cnt   <= '0;
          end
        end

        S_DATA: begin
          // Shift right with Din entering at the MSB, so bit 0 ends up at the LSB.
          shift <= {Din, shift[WIDTH-1:1]};
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) begin
`ifdef SERIAL_RX_PARITY_EN
            state <= S_PARITY;
`else
            state <= S_STOP;
`endif
          end
        end

`ifdef SERIAL_RX_PARITY_EN
        S_PARITY: begin
          par_bad <= parity_mismatch(shift, Din);
          state   <= S_STOP;
        end
`endif

        S_STOP: begin
          // Din low here is a framing error, never a new start bit.
          state <= S_IDLE;
          if (!Din) begin
            Frame_Err <= 1'b1;
`ifdef SERIAL_RX_PARITY_EN
          end else if (par_bad) begin
            Parity_Err <= 1'b1;
`endif
          end else begin
            Data_Out <= shift;
            Valid    <= 1'b1;
            Overrun  <= Valid & ~Ack;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

`ifndef SERIAL_RX_PARITY_EN
  assign Parity_Err = 1'b0;
`endif

endmodule

// File: doc/serial_rx_control.md
# serial_rx_control

Receive-side controller for the one-bit-per-clock serial link driven by the shift-register transmit datapath. It detects a start bit on the serial line and shifts WIDTH data bits in LSB first. It then checks the stop bit and presents the assembled word to the consumer with a level Valid/Ack handshake. The block sits between the link input pin and the register/display logic that consumes received words.

## Interface
- WIDTH, 8: data bits per frame, ≥2.
- Clk  in  1  system clock; all state updates on rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- Din  in  1  serial line; idle high.
- Ack  in  1  consumer acknowledge; clears Valid and Overrun.
- Data_Out  out  WIDTH  last good received word.
- Valid  out  1  Data_Out holds an unacknowledged word.
- Busy  out  1  frame in progress (state ≠ IDLE).
- Frame_Err  out  1  one-cycle pulse: stop bit sampled low.
- Parity_Err  out  1  one-cycle pulse: parity mismatch; tied 0 when parity is compiled out.
- Overrun  out  1  sticky: a good word overwrote an unacknowledged one.

## Operation
- Reset (async, Reset_n=0) drives these values:
  - state = IDLE
  - bit counter = 0
  - shift register = 0
  - Data_Out = 0
  - Valid, Busy, Frame_Err, Parity_Err, Overrun = 0
- States are IDLE, DATA, PARITY (present only with the macro) and STOP.
- IDLE: Din=0 at a rising edge is the start bit. The block moves to DATA and clears the counter. Din=1 keeps it in IDLE.
- DATA: each cycle, Din shifts into the MSB and the register shifts right, so bit 0 is received first.
  - The counter increments each cycle.
  - After WIDTH bits (counter = WIDTH-1 at that edge), the block moves to PARITY if compiled in, else STOP.
- PARITY: samples Din as an even-parity bit over the data bits, stores the mismatch flag, then moves to STOP.
- STOP: samples Din and always returns to IDLE. Outcomes by priority:
  - Din=0: Frame_Err pulses. Data_Out and Valid are unchanged, and the parity result is discarded.
  - Din=1 with parity mismatch: Parity_Err pulses. Data_Out and Valid are unchanged.
  - Din=1 with no mismatch: Data_Out is loaded from the shift register and Valid is set. If Valid was already 1 and Ack is 0 that cycle, Overrun is set.
- Ack=1 in any cycle clears Valid and Overrun, except when a good word loads in the same cycle (see Timing).
- No back-to-back gap is required. The block is back in IDLE the cycle after STOP and can accept a start bit immediately.
- Din=0 in STOP is never treated as a start bit. A new frame needs a start bit sampled in IDLE.
- Busy is combinational from state: 1 in DATA, PARITY and STOP.

## Timing
- Frame length is WIDTH+2 cycles (WIDTH+3 with parity):
  - start bit at edge 0
  - data at edges 1..WIDTH
  - parity at edge WIDTH+1 (when compiled in)
  - stop at the last edge
- Valid, Data_Out, Frame_Err and Parity_Err are registered. They change at the stop-sampling edge and are visible in the cycle after it.
- Error pulses last exactly one cycle.
- Ack is sampled at the edge. Valid drops in the cycle after Ack is high.
- Ack coincident with a good-word load: the load wins. Valid stays 1 with the new Data_Out, and Overrun is cleared (not set).
- Reset asserted mid-frame aborts immediately. Partial data is discarded, and the next frame needs a fresh start bit after Reset_n rises.
- Counter width is $clog2(WIDTH). The counter never wraps inside a frame because it is cleared on entry to DATA.

## Configuration
- SERIAL_RX_PARITY_EN defined:
  - the PARITY state exists and frames carry an even-parity bit after the data
  - Parity_Err is live
  - a word with a parity error is never delivered
- Undefined:
  - no PARITY state; DATA goes directly to STOP
  - Parity_Err is constant 0
  - frame length is WIDTH+2

## Test plan
- Reset mid-frame: drop Reset_n after 3 data bits, release, then send a clean frame 0x3C.
  - After reset, all outputs are 0 and Busy=0.
  - Only 0x3C is delivered, with Valid=1.
- Good frame, WIDTH=8, parity off: Din sequence 0, 1,0,1,0,0,1,0,1, 1 (0xA5 LSB first).
  - Cycle after stop: Data_Out=0xA5, Valid=1, Busy=0, no error.
  - Ack one cycle later: Valid=0.
- Frame error: 0x5A with stop bit 0.
  - Frame_Err high exactly one cycle; Data_Out keeps its prior value; Valid unchanged.
  - Next frame starting the following cycle is received correctly.
- Overrun and coincident Ack:
  - Send 0x11, no Ack, then 0x22: Data_Out=0x22, Valid=1, Overrun=1. Ack clears both.
  - Repeat with Ack high exactly on the 0x22 stop edge: Valid=1, Overrun=0.
- Parity (macro defined):
  - 0x07 with parity bit 1 plus stop 1: delivered.
  - 0x07 with parity bit 0: Parity_Err pulse, Valid unchanged.
  - Parity bad with stop 0: only Frame_Err pulses.
